oled_mode_arbiter: RTL and testbench
====================================

OLED_MODE_ARBITER -- requirements
Module: oled_mode_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 62500, is the number of clk cycles a synchronized sw value must hold before it is accepted (10 ms at 6.25 MHz).
REQ-002 Parameter BLANK_FRAMES, default 2, is the number of whole black frames inserted on every mode change.
REQ-003 Parameter IDLE_COLOR, default 16'hF81F, is the RGB565 fill colour used in IDLE mode.
REQ-004 clk  in  1  pixel clock (6.25 MHz), the same clock as Oled_Display; the only clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sw  in  4  raw slide switches, asynchronous to clk.
REQ-007 frame_begin  in  1  one-cycle pulse from Oled_Display at frame start.
REQ-008 pixel_a, pixel_b, pixel_c, pixel_d  in  16 each  RGB565 pixel data from tasks A-D.
REQ-009 pixel_data  out  16  pixel data to Oled_Display.
REQ-010 mode  out  3  current mode: 0 IDLE, 1 A, 2 B, 3 C, 4 D.
REQ-011 task_en  out  4  one-hot task run enables; bit0=A … bit3=D.
REQ-012 mode_changed  out  1  one-cycle pulse when mode takes a new value.
REQ-013 frame_cnt  out  8  frame counter; increments on each frame_begin and wraps from 255 to 0.

Function
REQ-014 sw shall pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced value sw_db shall update only after the synchronized sw has held the same value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-016 Decode of sw_db to target: 0001->1, 0010->2, 0100->3, 1000->4; every other value (including 0000 and multi-bit) ->0.
REQ-017 FSM states: RUN and BLANK.
REQ-018 RUN -> BLANK on a frame_begin when target != mode.
  - target is the registered value as of the previous cycle.
  - On entry: blank counter = BLANK_FRAMES, task_en = 0.
REQ-019 In BLANK, each frame_begin decrements the blank counter; the frame_begin that brings it to 0 returns the FSM to RUN.
  - On that cycle: mode = target (latest value), task_en = one-hot of that mode (0 for IDLE), mode_changed pulses.
REQ-020 A target change during BLANK shall not restart the blank; the exit takes the target current at exit.
  - If that target equals the old mode, the exit still occurs.
  - mode_changed pulses only if mode actually differs.
REQ-021 If BLANK_FRAMES = 0, a mode change completes on the same frame_begin with no blank frame.
REQ-022 pixel_data shall be combinational, zero latency, and valid in the same cycle for Oled_Display sampling:
  - BLANK -> 16'h0000.
  - RUN, mode 1-4 -> pixel_a/b/c/d respectively.
  - RUN, mode 0 -> IDLE_COLOR.
REQ-023 Mode and state shall never change except on a frame_begin cycle, so no frame mixes two sources.
REQ-024 frame_cnt shall increment on every frame_begin in both states.
REQ-025 A frame_begin asserted while target == mode in RUN shall have no effect other than the frame_cnt increment.

Reset
REQ-026 Asserting reset_n low shall immediately set all of the following, at any point including mid-BLANK:
  - state RUN, mode 0, task_en 0, mode_changed 0, frame_cnt 0, pixel_data IDLE_COLOR.
  - sw_db 0000, debounce counter 0, blank counter 0, synchronizer flops 0.
REQ-027 After reset release, a non-zero sw still held shall be debounced and applied through the normal BLANK sequence.

Verification (DEBOUNCE_CYCLES=4, BLANK_FRAMES=2, frame_begin every 20 cycles)
REQ-028 Reset, then sw=0000 and 3 frames -> mode=0, task_en=0000, pixel_data=F81F, frame_cnt=3.
REQ-029 sw=0010 held:
  - Next frame_begin -> BLANK, pixel_data=0000.
  - Second following frame_begin -> mode=2, task_en=0010, mode_changed one pulse, pixel_data=pixel_b.
REQ-030 Glitches:
  - sw toggles 0001 for 3 cycles then back to 0000 -> no BLANK, mode stays 0.
  - sw=0011 held -> mode stays 0.
REQ-031 In mode 2, sw=1000 then back to 0010 mid-BLANK:
  - BLANK completes 2 frames, then mode=2.
  - task_en=0010 restored, no mode_changed pulse.
REQ-032 reset_n pulsed low mid-BLANK -> immediate mode=0, task_en=0, frame_cnt=0; 256 frames later frame_cnt=0 (wrap).

Source files
------------

// File: rtl/oled_mode_arbiter_if.sv
// Bundle of switch, frame-strobe and pixel signals exchanged between the
// board-level driver side and the OLED mode arbiter.
interface oled_mode_arbiter_if;
   logic [3:0]  sw;
   logic        frame_begin;
   logic [15:0] pixel_a;
   logic [15:0] pixel_b;
   logic [15:0] pixel_c;
   logic [15:0] pixel_d;
   logic [15:0] pixel_data;
   logic [2:0]  mode;
   logic [3:0]  task_en;
   logic        mode_changed;
   logic [7:0]  frame_cnt;

   modport master (
      output sw, frame_begin, pixel_a, pixel_b, pixel_c, pixel_d,
      input  pixel_data, mode, task_en, mode_changed, frame_cnt
   );

   modport slave (
      input  sw, frame_begin, pixel_a, pixel_b, pixel_c, pixel_d,
      output pixel_data, mode, task_en, mode_changed, frame_cnt
   );
endinterface

// File: rtl/oled_mode_arbiter.sv
// Selects which task drives the OLED from debounced slide switches, inserting
// whole black frames around every source change so no frame mixes two sources.
module oled_mode_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 62500,
   parameter int unsigned BLANK_FRAMES    = 2,
   parameter logic [15:0] IDLE_COLOR      = 16'hF81F
) (
   input  logic               clk,
   input  logic               reset_n,
   oled_mode_arbiter_if.slave bus
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BLK_W = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES + 1);
   localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK_FRAMES);

   typedef enum logic {ST_RUN, ST_BLANK} state_e;

   function automatic logic [2:0] decode_target(input logic [3:0] s);
      logic [2:0] t;
      unique case (s)
         4'b0001: t = 3'd1;
         4'b0010: t = 3'd2;
         4'b0100: t = 3'd3;
         4'b1000: t = 3'd4;
         default: t = 3'd0;
      endcase
      return t;
   endfunction

   function automatic logic [3:0] mode_onehot(input logic [2:0] m);
      logic [3:0] oh;
      unique case (m)
         3'd1:    oh = 4'b0001;
         3'd2:    oh = 4'b0010;
         3'd3:    oh = 4'b0100;
         3'd4:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       stable_q, sw_db_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic [2:0]       target_q, target_d;
   state_e           state_q;
   logic [BLK_W-1:0] blk_cnt_q;
   logic [2:0]       mode_q;
   logic [3:0]       task_en_q;
   logic             mode_changed_q;
   logic [7:0]       frame_cnt_q;
   logic [15:0]      pixel_d;

   assign target_d = decode_target(sw_db_q);

   // Front end: synchronize, debounce, then register the decoded target.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         db_cnt_q <= '0;
         sw_db_q  <= '0;
         target_q <= '0;
      end else begin
         sync1_q  <= bus.sw;
         sync2_q  <= sync1_q;
         if (sync2_q != stable_q) begin
            stable_q <= sync2_q;
            db_cnt_q <= CNT_W'(1);
         end else if (db_cnt_q < DB_LIMIT) begin
            db_cnt_q <= db_cnt_q + CNT_W'(1);
         end
         if (db_cnt_q >= DB_LIMIT) begin
            sw_db_q <= stable_q;
         end
         target_q <= target_d;
      end
   end

   // Mode FSM: every state or mode update is gated by frame_begin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_RUN;
         blk_cnt_q      <= '0;
         mode_q         <= 3'd0;
         task_en_q      <= 4'b0000;
         mode_changed_q <= 1'b0;
         frame_cnt_q    <= 8'd0;
      end else begin
         mode_changed_q <= 1'b0;
         if (bus.frame_begin) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            unique case (state_q)
               ST_RUN: begin
                  if (target_q != mode_q) begin
                     if (BLANK_FRAMES == 0) begin
                        mode_q         <= target_q;
                        task_en_q      <= mode_onehot(target_q);
                        mode_changed_q <= 1'b1;
                     end else begin
                        state_q   <= ST_BLANK;
                        blk_cnt_q <= BLK_INIT;
                        task_en_q <= 4'b0000;
                     end
                  end
               end
               ST_BLANK: begin
                  // Exit takes whatever target is current now, even the old mode.
                  if (blk_cnt_q <= BLK_W'(1)) begin
                     state_q        <= ST_RUN;
                     blk_cnt_q      <= '0;
                     mode_q         <= target_q;
                     task_en_q      <= mode_onehot(target_q);
                     mode_changed_q <= (target_q != mode_q);
                  end else begin
                     blk_cnt_q <= blk_cnt_q - BLK_W'(1);
                  end
               end
               default: state_q <= ST_RUN;
            endcase
         end
      end
   end

   always_comb begin
      pixel_d = IDLE_COLOR;
      if (state_q == ST_BLANK) begin
         pixel_d = 16'h0000;
      end else begin
         unique case (mode_q)
            3'd1:    pixel_d = bus.pixel_a;
            3'd2:    pixel_d = bus.pixel_b;
            3'd3:    pixel_d = bus.pixel_c;
            3'd4:    pixel_d = bus.pixel_d;
            default: pixel_d = IDLE_COLOR;
         endcase
      end
   end

   assign bus.pixel_data   = pixel_d;
   assign bus.mode         = mode_q;
   assign bus.task_en      = task_en_q;
   assign bus.mode_changed = mode_changed_q;
   assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_oled_mode_arbiter.sv
// Directed bench for oled_mode_arbiter: a frame-level model checked every cycle
// plus literal expectations at key points of the mode-change sequences.
module tb_oled_mode_arbiter;
   localparam int          DB   = 4;
   localparam int          BF   = 2;
   localparam logic [15:0] IDLE = 16'hF81F;
   localparam logic [15:0] PA   = 16'h1A2B;
   localparam logic [15:0] PB   = 16'h2C3D;
   localparam logic [15:0] PC   = 16'h3E4F;
   localparam logic [15:0] PD   = 16'h4051;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   mc_seen = 0;
   int   phase = 0;

   oled_mode_arbiter_if bus_if();

   oled_mode_arbiter #(
      .DEBOUNCE_CYCLES(DB),
      .BLANK_FRAMES   (BF),
      .IDLE_COLOR     (IDLE)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the switches mean and where the frame sequence stands.
   int          m_run_len;
   logic [3:0]  m_cur_sw, m_db;
   logic [2:0]  m_mode;
   logic        m_blank;
   int          m_blanks_left;
   logic [7:0]  m_fcnt;
   logic        m_mc;

   function automatic logic [2:0] sw_to_mode(input logic [3:0] s);
      if (s == 4'b0001) return 3'd1;
      if (s == 4'b0010) return 3'd2;
      if (s == 4'b0100) return 3'd3;
      if (s == 4'b1000) return 3'd4;
      return 3'd0;
   endfunction

   function automatic logic [3:0] exp_task_en();
      if (m_blank || m_mode == 3'd0) return 4'b0000;
      return 4'(1 << (m_mode - 3'd1));
   endfunction

   function automatic logic [15:0] exp_pixel();
      logic [15:0] srcs [5];
      srcs[0] = IDLE; srcs[1] = PA; srcs[2] = PB; srcs[3] = PC; srcs[4] = PD;
      if (m_blank) return 16'h0000;
      return srcs[m_mode];
   endfunction

   task automatic model_step();
      logic [2:0] tgt;
      if (!reset_n) begin
         m_run_len = 0; m_cur_sw = 4'b0; m_db = 4'b0; m_mode = 3'd0;
         m_blank = 1'b0; m_blanks_left = 0; m_fcnt = 8'd0; m_mc = 1'b0;
      end else begin
         m_mc = 1'b0;
         if (bus_if.sw == m_cur_sw) begin
            if (m_run_len < 1000) m_run_len++;
         end else begin
            m_cur_sw  = bus_if.sw;
            m_run_len = 1;
         end
         if (m_run_len >= DB) m_db = m_cur_sw;
         if (bus_if.frame_begin) begin
            m_fcnt = m_fcnt + 8'd1;
            tgt = sw_to_mode(m_db);
            if (m_blank) begin
               m_blanks_left--;
               if (m_blanks_left == 0) begin
                  m_blank = 1'b0;
                  m_mc    = (tgt != m_mode);
                  m_mode  = tgt;
               end
            end else if (tgt != m_mode) begin
               m_blank       = 1'b1;
               m_blanks_left = BF;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         model_step();
         if (bus_if.mode_changed === 1'b1) mc_seen++;
         check("mode",         32'(bus_if.mode),         32'(m_mode));
         check("task_en",      32'(bus_if.task_en),      32'(exp_task_en()));
         check("mode_changed", 32'(bus_if.mode_changed), 32'(m_mc));
         check("frame_cnt",    32'(bus_if.frame_cnt),    32'(m_fcnt));
         check("pixel_data",   32'(bus_if.pixel_data),   32'(exp_pixel()));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      bus_if.frame_begin = (phase == 0);
      phase = (phase == 19) ? 0 : phase + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         bus_if.frame_begin = 1'b0;
      end
   endtask

   // Runs until k frame_begin pulses have been clocked in, then one more cycle.
   task automatic run_frames(input int k);
      int n = 0;
      while (n < k) begin
         tick();
         if (bus_if.frame_begin) n++;
      end
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n            = 1'b0;
      bus_if.sw          = 4'b0000;
      bus_if.frame_begin = 1'b0;
      bus_if.pixel_a     = PA;
      bus_if.pixel_b     = PB;
      bus_if.pixel_c     = PC;
      bus_if.pixel_d     = PD;
      idle(4);
      check("rst_mode",    32'(bus_if.mode),       32'd0);
      check("rst_task_en", 32'(bus_if.task_en),    32'd0);
      check("rst_frame",   32'(bus_if.frame_cnt),  32'd0);
      check("rst_pixel",   32'(bus_if.pixel_data), 32'hF81F);
      reset_n = 1'b1;
      phase   = 0;

      run_frames(3);
      check("idle_mode",    32'(bus_if.mode),       32'd0);
      check("idle_task_en", 32'(bus_if.task_en),    32'd0);
      check("idle_pixel",   32'(bus_if.pixel_data), 32'hF81F);
      check("idle_frames",  32'(bus_if.frame_cnt),  32'd3);

      // Three-cycle glitch must not survive the debouncer.
      tick(); bus_if.sw = 4'b0001;
      tick(); tick(); tick(); bus_if.sw = 4'b0000;
      run_frames(2);
      check("glitch_mode",  32'(bus_if.mode),       32'd0);
      check("glitch_pixel", 32'(bus_if.pixel_data), 32'hF81F);
      check("glitch_frames",32'(bus_if.frame_cnt),  32'd5);

      tick(); bus_if.sw = 4'b0011;
      run_frames(2);
      check("multi_mode",    32'(bus_if.mode),    32'd0);
      check("multi_task_en", 32'(bus_if.task_en), 32'd0);

      tick(); bus_if.sw = 4'b0010;
      run_frames(1);
      check("b_blank_pixel", 32'(bus_if.pixel_data), 32'h0000);
      check("b_blank_ten",   32'(bus_if.task_en),    32'd0);
      run_frames(2);
      check("b_mode",    32'(bus_if.mode),       32'd2);
      check("b_task_en", 32'(bus_if.task_en),    32'b0010);
      check("b_pixel",   32'(bus_if.pixel_data), 32'(PB));
      check("b_pulses",  32'(mc_seen),           32'd1);

      // Switch away and back during BLANK: blank runs out, same mode, no pulse.
      tick(); bus_if.sw = 4'b1000;
      run_frames(1);
      check("bounce_blank", 32'(bus_if.pixel_data), 32'h0000);
      tick(); bus_if.sw = 4'b0010;
      run_frames(2);
      check("bounce_mode",    32'(bus_if.mode),       32'd2);
      check("bounce_task_en", 32'(bus_if.task_en),    32'b0010);
      check("bounce_pixel",   32'(bus_if.pixel_data), 32'(PB));
      check("bounce_pulses",  32'(mc_seen),           32'd1);

      tick(); bus_if.sw = 4'b0100;
      run_frames(3);
      check("c_mode",   32'(bus_if.mode),       32'd3);
      check("c_pixel",  32'(bus_if.pixel_data), 32'(PC));
      check("c_pulses", 32'(mc_seen),           32'd2);

      // Reset in the middle of a BLANK sequence takes effect at once.
      tick(); bus_if.sw = 4'b0001;
      run_frames(1);
      tick(); tick();
      reset_n = 1'b0;
      #1;
      check("midrst_mode",    32'(bus_if.mode),         32'd0);
      check("midrst_task_en", 32'(bus_if.task_en),      32'd0);
      check("midrst_frame",   32'(bus_if.frame_cnt),    32'd0);
      check("midrst_pixel",   32'(bus_if.pixel_data),   32'hF81F);
      check("midrst_mc",      32'(bus_if.mode_changed), 32'd0);
      idle(3);
      reset_n = 1'b1;
      phase   = 0;
      run_frames(256);
      check("wrap_frame",   32'(bus_if.frame_cnt),  32'd0);
      check("wrap_mode",    32'(bus_if.mode),       32'd1);
      check("wrap_task_en", 32'(bus_if.task_en),    32'b0001);
      check("wrap_pixel",   32'(bus_if.pixel_data), 32'(PA));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
